ppu_linemult_modeswitch_ctrl: RTL

//  Sequences safe line-multiplier mode changes for the PPU output path. Owns VCLK_Tx_select and the

---
 rtl/ppu_linemult_modeswitch_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ppu_linemult_modeswitch_ctrl.sv
// Line-multiplier mode-switch sequencer: mute, wait for vsync, switch VCLK_Tx select, reset Tx domain, settle, unmute.
// Optional MUTE_WAIT watchdog enabled by defining PPU_MODESW_WATCHDOG_EN.
module ppu_linemult_modeswitch_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int SETTLE_FRAMES = 2
`ifdef PPU_MODESW_WATCHDOG_EN
   , parameter int WD_CYCLES   = 2**21
`endif
) (
   input  logic       VCLK,
   input  logic       nVRST_Tx,
   input  logic       nVDSYNC,
   input  logic [3:0] Sync_i,
   input  logic [1:0] linemult_req,
   input  logic       testpat_req,
   input  logic       use_vpll,
   output logic [1:0] VCLK_Tx_select,
   output logic [1:0] linemult_act,
   output logic       nMUTE,
   output logic       nRST_Tx_req,
   output logic       busy,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_MUTE_WAIT = 3'd1,
      ST_SWITCH    = 3'd2,
      ST_HOLD_RST  = 3'd3,
      ST_SETTLE    = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] fcnt_q, fcnt_d;
   logic [1:0] target_q, target_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] act_q, act_d;
   logic       nmute_q, nmute_d;
   logic       nrst_q, nrst_d;
   logic       vs_prev_q;
   logic       vs_fall;
   logic       wd_expired;
   logic       unused_sync;

   assign unused_sync = ^Sync_i[2:0];

   // Sync_i is only meaningful while the data strobe is low.
   assign vs_fall = !nVDSYNC && vs_prev_q && !Sync_i[3];

   always_comb begin
      target_d = linemult_req;
      if (testpat_req || linemult_req == 2'b11)
         target_d = 2'b00;
      else if (linemult_req == 2'b10 && !use_vpll)
         target_d = 2'b01;
   end

`ifdef PPU_MODESW_WATCHDOG_EN
   localparam int WD_W = $clog2(WD_CYCLES + 1);
   logic [WD_W-1:0] wd_q;

   assign wd_expired = (wd_q == WD_W'(WD_CYCLES - 1));

   // Cleared outside MUTE_WAIT, so every MUTE_WAIT entry starts counting from zero.
   always_ff @(posedge VCLK or negedge nVRST_Tx) begin
      if (!nVRST_Tx)
         wd_q <= '0;
      else if (state_q == ST_MUTE_WAIT && !wd_expired)
         wd_q <= wd_q + WD_W'(1);
      else
         wd_q <= '0;
   end
`else
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fcnt_d  = fcnt_q;
      sel_d   = sel_q;
      act_d   = act_q;
      nmute_d = nmute_q;
      nrst_d  = nrst_q;
      case (state_q)
         ST_IDLE: begin
            if (target_q != act_q) begin
               state_d = ST_MUTE_WAIT;
               nmute_d = 1'b0;
            end
         end
         ST_MUTE_WAIT: begin
            nmute_d = 1'b0;
            // A request that reverts wins over a coincident vsync edge.
            if (target_q == act_q) begin
               state_d = ST_IDLE;
               nmute_d = 1'b1;
            end else if (vs_fall || wd_expired) begin
               state_d = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            sel_d   = target_q;
            act_d   = target_q;
            nrst_d  = 1'b0;
            cnt_d   = 8'(RST_CYCLES);
            state_d = ST_HOLD_RST;
         end
         ST_HOLD_RST: begin
            if (cnt_q <= 8'd1) begin
               nrst_d  = 1'b1;
               fcnt_d  = 4'(SETTLE_FRAMES);
               state_d = ST_SETTLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         ST_SETTLE: begin
            // A new request while settling goes straight back to waiting, still muted.
            if (target_q != act_q) begin
               state_d = ST_MUTE_WAIT;
            end else if (vs_fall) begin
               if (fcnt_q <= 4'd1) begin
                  state_d = ST_IDLE;
                  nmute_d = 1'b1;
               end else begin
                  fcnt_d = fcnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = ST_HOLD_RST;
            cnt_d   = 8'(RST_CYCLES);
            nrst_d  = 1'b0;
            nmute_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge VCLK or negedge nVRST_Tx) begin
      if (!nVRST_Tx) begin
         state_q   <= ST_HOLD_RST;
         cnt_q     <= 8'(RST_CYCLES);
         fcnt_q    <= 4'(SETTLE_FRAMES);
         target_q  <= 2'b00;
         sel_q     <= 2'b00;
         act_q     <= 2'b00;
         nmute_q   <= 1'b0;
         nrst_q    <= 1'b0;
         vs_prev_q <= 1'b1;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         fcnt_q   <= fcnt_d;
         target_q <= target_d;
         sel_q    <= sel_d;
         act_q    <= act_d;
         nmute_q  <= nmute_d;
         nrst_q   <= nrst_d;
         if (!nVDSYNC)
            vs_prev_q <= Sync_i[3];
      end
   end

   assign VCLK_Tx_select = sel_q;
   assign linemult_act   = act_q;
   assign nMUTE          = nmute_q;
   assign nRST_Tx_req    = nrst_q;
   assign busy           = (state_q != ST_IDLE);
   assign state_o        = state_q;

endmodule
